frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Job-level controller in front of the image-processing top level (counters, engine, pixel buffer, core).
- Accepts frame jobs (width, height) from software/host logic into a small FIFO.
- For each job it drives the frame size, issues the one-cycle start pulse, and counts valid output pixels to detect frame completion.
- Between frames it enforces a programmable idle gap so the pipeline fully drains before the next start.

Parameters:
- DEPTH, 4, job FIFO entries; power of 2, ≥2.
- SIZE_W, 12, width of the size_x/size_y fields.
- GAP_CYCLES, 4, idle cycles between frame_done and the next start; 0 allowed.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  core clock
- rst  in  1  system reset, asynchronous, active-low
- job_valid  in  1  job request
- job_ready  out  1  FIFO can accept a job
- job_size_x  in  SIZE_W  requested image width
- job_size_y  in  SIZE_W  requested image height
- dut_start  out  1  start pulse to the datapath
- dut_size_x  out  SIZE_W  width driven to the datapath, held for the whole frame
- dut_size_y  out  SIZE_W  height driven to the datapath, held for the whole frame
- pixel_valid  in  1  output-pixel-valid from the datapath
- busy  out  1  frame in flight (START, RUN, DONE or GAP)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame
- job_err  out  1  one-cycle pulse when a zero-size job is dropped
- stray_pixel  out  1  sticky flag: pixel_valid seen outside RUN
- frames_done  out  CNT_W  completed-frame count, wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; state=IDLE.
  - All outputs 0, except job_ready=1.
  - Pixel and gap counters cleared.
  - Reset mid-frame aborts the frame; no frame_done is issued.
- FIFO:
  - job_ready = !full, combinational from the registered count.
  - Push on job_valid && job_ready.
  - When full, job_ready=0 even if a pop happens in the same cycle (no pass-through).
- States:
  - IDLE: if FIFO non-empty → LOAD.
  - LOAD: pop the head entry.
    - If size_x==0 or size_y==0: job_err=1 for 1 cycle, → IDLE; frame not started, not counted.
    - Otherwise register dut_size_x/dut_size_y and total = size_x*size_y (2*SIZE_W bits, unsigned, no truncation); → START.
  - START: dut_start=1 for exactly this cycle; pixel count cleared; → RUN.
  - RUN: count pixel_valid cycles. When pixel_valid arrives with count==total-1 → DONE.
  - DONE: frame_done=1 for 1 cycle; frames_done += 1 (wraps at 2^CNT_W). → GAP if GAP_CYCLES>0, else → IDLE.
  - GAP: stay exactly GAP_CYCLES cycles, then → IDLE.
- Latency:
  - Handshake in cycle C with the FIFO empty and state IDLE: LOAD in C+1, dut_start in C+2.
  - Back-to-back jobs: next dut_start comes GAP_CYCLES+3 cycles after the frame_done cycle.
- dut_size_x/dut_size_y change only in LOAD; they are stable from START through GAP.
- busy=1 in START, RUN, DONE and GAP.
- pixel_valid outside RUN (including in START) is ignored for counting and sets stray_pixel. stray_pixel clears only on reset.
- A push while busy is accepted normally; running-frame parameters are unaffected.

Optional Feature:
- Macro: FRAME_SEQ_TIMEOUT_EN.
- With the macro defined:
  - Extra parameter TIMEOUT_CYCLES (default 65535).
  - Extra output timeout (1 bit, sticky, reset 0).
  - In RUN, a watchdog counter is cleared on each pixel_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: timeout=1, state → GAP, no frame_done, frames_done not incremented.
- Without the macro: no watchdog logic, no timeout port, and RUN waits indefinitely.

Test Plan:
- Reset, then one job 4x3 with pixel_valid held high from the cycle after dut_start:
  - dut_start exactly 2 cycles after the handshake.
  - frame_done on the cycle after the 12th valid.
  - frames_done=1.
- Push 5 jobs (2x2) back-to-back with DEPTH=4 while the first is running:
  - job_ready drops to 0 once full; the 5th is accepted after the first pop.
  - 5 frame_done pulses; dut_start spacing ≥ GAP_CYCLES+3 after each frame_done.
- Job 0x5 followed by 3x1:
  - job_err pulses once; no dut_start for the first job.
  - The 3x1 frame completes; frames_done=1.
- Job 2x2 with pixel_valid gapped (1,0,1,0,1,1) and a pixel_valid pulse during GAP:
  - frame_done after the 4th valid.
  - stray_pixel=1; frames_done=1.
- Assert rst=0 mid-RUN after 3 of 16 pixels (4x4):
  - All outputs immediately 0, job_ready=1, no frame_done.
  - A new 1x1 job then completes normally.
- With FRAME_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=10, job 2x2 with only 1 pixel_valid:
  - timeout=1 ten cycles after that pixel; no frame_done.
  - A following job still runs.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// frame_sequencer_if
// Groups the job intake, datapath control and status signals of the frame
// sequencer into a single bundle.
//   master : host / datapath side (drives job requests and pixel_valid)
//   slave  : the sequencer itself
// Signals:
//   job_valid/job_ready/job_size_x/job_size_y : job request handshake
//   dut_start/dut_size_x/dut_size_y           : frame control to datapath
//   pixel_valid                               : output-pixel-valid from datapath
//   busy/frame_done/job_err/stray_pixel       : status
//   frames_done                               : completed-frame counter
//   timeout (FRAME_SEQ_TIMEOUT_EN only)       : sticky watchdog flag
// -----------------------------------------------------------------------------
interface frame_sequencer_if #(
  parameter int unsigned SIZE_W = 12,
  parameter int unsigned CNT_W  = 16
);
  logic              job_valid;
  logic              job_ready;
  logic [SIZE_W-1:0] job_size_x;
  logic [SIZE_W-1:0] job_size_y;
  logic              dut_start;
  logic [SIZE_W-1:0] dut_size_x;
  logic [SIZE_W-1:0] dut_size_y;
  logic              pixel_valid;
  logic              busy;
  logic              frame_done;
  logic              job_err;
  logic              stray_pixel;
  logic [CNT_W-1:0]  frames_done;
`ifdef FRAME_SEQ_TIMEOUT_EN
  logic              timeout;
`endif

  modport master (
    output job_valid, job_size_x, job_size_y, pixel_valid,
    input  job_ready, dut_start, dut_size_x, dut_size_y, busy,
           frame_done, job_err, stray_pixel, frames_done
`ifdef FRAME_SEQ_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  job_valid, job_size_x, job_size_y, pixel_valid,
    output job_ready, dut_start, dut_size_x, dut_size_y, busy,
           frame_done, job_err, stray_pixel, frames_done
`ifdef FRAME_SEQ_TIMEOUT_EN
    , output timeout
`endif
  );
endinterface

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Job-level controller in front of the image-processing pipeline. Frame jobs
// (width, height) are queued in a DEPTH-entry FIFO. For each job the sequencer
// drives the frame size, issues a one-cycle start pulse, counts valid output
// pixels until width*height have been seen, pulses frame_done and then holds
// off GAP_CYCLES idle cycles so the pipeline drains before the next start.
// Zero-size jobs are dropped with a job_err pulse.
//
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : frame_sequencer_if.slave (job intake, datapath control, status)
//
// Optional feature (macro FRAME_SEQ_TIMEOUT_EN): RUN-state watchdog. If no
// pixel_valid arrives for TIMEOUT_CYCLES cycles the frame is abandoned
// (no frame_done, not counted), the sticky timeout flag is set and the
// sequencer proceeds through the idle gap.
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned SIZE_W         = 12,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned CNT_W          = 16
`ifdef FRAME_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  frame_sequencer_if.slave bus
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned TOT_W  = 2 * SIZE_W;
  localparam logic [FCNT_W-1:0] FULL_LVL = FCNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Job FIFO storage and control
  logic [SIZE_W-1:0] mem_x_q [DEPTH];
  logic [SIZE_W-1:0] mem_y_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic [SIZE_W-1:0] head_x_s;
  logic [SIZE_W-1:0] head_y_s;

  // Sequencer state
  state_t            state_q;
  logic [TOT_W-1:0]  total_q;
  logic [TOT_W-1:0]  pix_cnt_q;
  logic [31:0]       gap_cnt_q;
  logic              dut_start_q;
  logic [SIZE_W-1:0] dut_size_x_q;
  logic [SIZE_W-1:0] dut_size_y_q;
  logic              busy_q;
  logic              frame_done_q;
  logic              job_err_q;
  logic              stray_q;
  logic [CNT_W-1:0]  frames_done_q;
`ifdef FRAME_SEQ_TIMEOUT_EN
  logic [31:0]       wd_cnt_q;
  logic              timeout_q;
`endif

  // Ready comes from the registered level only, so a full FIFO refuses a push
  // even in a cycle where LOAD pops.
  assign full_s   = (fcnt_q == FULL_LVL);
  assign push_s   = bus.job_valid && !full_s;
  assign pop_s    = (state_q == S_LOAD);
  assign head_x_s = mem_x_q[rd_ptr_q];
  assign head_y_s = mem_y_q[rd_ptr_q];

  // FIFO payload storage (no reset needed; validity tracked by fcnt_q)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_x_q[wr_ptr_q] <= bus.job_size_x;
      mem_y_q[wr_ptr_q] <= bus.job_size_y;
    end
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // Frame sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      total_q       <= '0;
      pix_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      dut_start_q   <= 1'b0;
      dut_size_x_q  <= '0;
      dut_size_y_q  <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      job_err_q     <= 1'b0;
      stray_q       <= 1'b0;
      frames_done_q <= '0;
`ifdef FRAME_SEQ_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      dut_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      job_err_q    <= 1'b0;

      if (bus.pixel_valid && (state_q != S_RUN)) begin
        stray_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // Looking at the push as well gives LOAD the cycle after a handshake
          // into an empty FIFO.
          if ((fcnt_q != '0) || push_s) begin
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          if ((head_x_s == '0) || (head_y_s == '0)) begin
            job_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            dut_size_x_q <= head_x_s;
            dut_size_y_q <= head_y_s;
            total_q      <= TOT_W'(head_x_s) * TOT_W'(head_y_s);
            pix_cnt_q    <= '0;
            dut_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end

        S_START: begin
          pix_cnt_q <= '0;
`ifdef FRAME_SEQ_TIMEOUT_EN
          wd_cnt_q  <= '0;
`endif
          state_q   <= S_RUN;
        end

        S_RUN: begin
          if (bus.pixel_valid) begin
`ifdef FRAME_SEQ_TIMEOUT_EN
            wd_cnt_q <= '0;
`endif
            if (pix_cnt_q == (total_q - TOT_W'(1))) begin
              frame_done_q  <= 1'b1;
              frames_done_q <= frames_done_q + CNT_W'(1);
              state_q       <= S_DONE;
            end else begin
              pix_cnt_q <= pix_cnt_q + TOT_W'(1);
            end
          end else begin
`ifdef FRAME_SEQ_TIMEOUT_EN
            // Counter value reaches TIMEOUT_CYCLES on this edge: abandon frame.
            if (wd_cnt_q == WD_LAST) begin
              timeout_q <= 1'b1;
              gap_cnt_q <= '0;
              if (GAP_CYCLES > 0) begin
                state_q <= S_GAP;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              wd_cnt_q <= wd_cnt_q + 32'd1;
            end
`else
            pix_cnt_q <= pix_cnt_q;
`endif
          end
        end

        S_DONE: begin
          gap_cnt_q <= '0;
          if (GAP_CYCLES > 0) begin
            state_q <= S_GAP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.job_ready   = !full_s;
  assign bus.dut_start   = dut_start_q;
  assign bus.dut_size_x  = dut_size_x_q;
  assign bus.dut_size_y  = dut_size_y_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.job_err     = job_err_q;
  assign bus.stray_pixel = stray_q;
  assign bus.frames_done = frames_done_q;
`ifdef FRAME_SEQ_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
// Directed test of frame_sequencer with DEPTH=4, SIZE_W=12, GAP_CYCLES=4,
// CNT_W=16 (TIMEOUT_CYCLES=10 when FRAME_SEQ_TIMEOUT_EN is defined).
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;
  localparam int GAP = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  frame_sequencer_if #(.SIZE_W(12), .CNT_W(16)) bus ();

  frame_sequencer #(
    .DEPTH(4), .SIZE_W(12), .GAP_CYCLES(GAP), .CNT_W(16)
`ifdef FRAME_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel valid is the OR of a manual drive and an auto responder.
  logic man_pv;
  logic auto_pv;
  int   auto_pix;
  assign bus.pixel_valid = man_pv | auto_pv;

  // Auto responder: after each dut_start, auto_pix consecutive valid cycles.
  initial begin
    int rem;
    rem = 0;
    auto_pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.dut_start === 1'b1) begin
        rem = auto_pix;
        auto_pv = 1'b0;
      end else if (rem > 0) begin
        auto_pv = 1'b1;
        rem = rem - 1;
      end else begin
        auto_pv = 1'b0;
      end
    end
  end

  // Event monitor sampled on the falling edge.
  int cyc, done_cnt, start_cnt, err_cnt, last_done, spacing_n, spacing_bad;
  logic track, have_done;
  initial begin
    cyc = 0; done_cnt = 0; start_cnt = 0; err_cnt = 0; last_done = 0;
    spacing_n = 0; spacing_bad = 0; have_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (bus.dut_start === 1'b1) begin
        start_cnt = start_cnt + 1;
        if (track && have_done) begin
          spacing_n = spacing_n + 1;
          if (cyc - last_done != GAP + 3) spacing_bad = spacing_bad + 1;
        end
      end
      if (bus.frame_done === 1'b1) begin
        done_cnt = done_cnt + 1;
        last_done = cyc;
        have_done = track;
      end
      if (bus.job_err === 1'b1) err_cnt = err_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n = n + 1;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic push_one(input logic [11:0] x, input logic [11:0] y);
    bus.job_valid  = 1'b1;
    bus.job_size_x = x;
    bus.job_size_y = y;
    step();
    bus.job_valid  = 1'b0;
  endtask

  initial begin
    int d0, s0, e0;
    logic [5:0] pat;
    total = 0; bad = 0;
    track = 1'b0;
    man_pv = 1'b0;
    auto_pix = 0;
    bus.job_valid = 1'b0;
    bus.job_size_x = 12'd0;
    bus.job_size_y = 12'd0;
    rst_n = 1'b0;

    // ---------------- reset state
    repeat (2) step();
    check("rst_job_ready", 32'(bus.job_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_start", 32'(bus.dut_start), 32'd0);
    check("rst_frames", 32'(bus.frames_done), 32'd0);
    check("rst_size_x", 32'(bus.dut_size_x), 32'd0);
    rst_n = 1'b1;
    step();

    // ---------------- 4x3 frame, pixels from the cycle after dut_start
    push_one(12'd4, 12'd3);             // now in LOAD
    check("t1_load_nostart", 32'(bus.dut_start), 32'd0);
    check("t1_load_notbusy", 32'(bus.busy), 32'd0);
    step();                             // START
    check("t1_start", 32'(bus.dut_start), 32'd1);
    check("t1_size_x", 32'(bus.dut_size_x), 32'd4);
    check("t1_size_y", 32'(bus.dut_size_y), 32'd3);
    check("t1_busy", 32'(bus.busy), 32'd1);
    step();                             // RUN
    check("t1_start_1cyc", 32'(bus.dut_start), 32'd0);
    man_pv = 1'b1;
    repeat (11) step();
    check("t1_no_early_done", 32'(bus.frame_done), 32'd0);
    step();
    man_pv = 1'b0;
    check("t1_frame_done", 32'(bus.frame_done), 32'd1);
    check("t1_frames", 32'(bus.frames_done), 32'd1);
    step();
    check("t1_done_1cyc", 32'(bus.frame_done), 32'd0);
    check("t1_gap_busy", 32'(bus.busy), 32'd1);
    repeat (GAP) step();
    check("t1_idle", 32'(bus.busy), 32'd0);
    check("t1_no_stray", 32'(bus.stray_pixel), 32'd0);

    // ---------------- 5 back-to-back 2x2 jobs, FIFO fills
    track = 1'b1;
    auto_pix = 4;
    d0 = done_cnt;
    bus.job_valid  = 1'b1;
    bus.job_size_x = 12'd2;
    bus.job_size_y = 12'd2;
    repeat (4) step();
    check("t2_ready_before_full", 32'(bus.job_ready), 32'd1);
    step();
    bus.job_valid = 1'b0;
    check("t2_ready_full", 32'(bus.job_ready), 32'd0);
    wait_frames(d0 + 5, 200, "t2_five_frames");
    repeat (GAP + 4) step();
    check("t2_frames", 32'(bus.frames_done), 32'd6);
    check("t2_spacing_n", 32'(spacing_n), 32'd4);
    check("t2_spacing_bad", 32'(spacing_bad), 32'd0);
    check("t2_ready_empty", 32'(bus.job_ready), 32'd1);
    check("t2_idle", 32'(bus.busy), 32'd0);
    track = 1'b0;

    // ---------------- 0x5 dropped, 3x1 runs
    auto_pix = 3;
    d0 = done_cnt; s0 = start_cnt; e0 = err_cnt;
    bus.job_valid  = 1'b1;
    bus.job_size_x = 12'd0;
    bus.job_size_y = 12'd5;
    step();
    bus.job_size_x = 12'd3;
    bus.job_size_y = 12'd1;
    step();
    bus.job_valid = 1'b0;
    wait_frames(d0 + 1, 100, "t3_frame");
    repeat (GAP + 4) step();
    check("t3_err_once", 32'(err_cnt - e0), 32'd1);
    check("t3_one_start", 32'(start_cnt - s0), 32'd1);
    check("t3_frames", 32'(bus.frames_done), 32'd7);
    check("t3_size_x", 32'(bus.dut_size_x), 32'd3);
    check("t3_size_y", 32'(bus.dut_size_y), 32'd1);

    // ---------------- 2x2 with gapped pixels, stray pixel in GAP
    auto_pix = 0;
    pat = 6'b110101;                    // applied LSB first: 1,0,1,0,1,1
    push_one(12'd2, 12'd2);             // LOAD
    step();                             // START
    check("t4_start", 32'(bus.dut_start), 32'd1);
    step();                             // RUN
    for (int i = 0; i < 6; i++) begin
      man_pv = pat[i];
      step();
      if (i == 4) check("t4_no_early_done", 32'(bus.frame_done), 32'd0);
    end
    man_pv = 1'b0;
    check("t4_frame_done", 32'(bus.frame_done), 32'd1);
    check("t4_frames", 32'(bus.frames_done), 32'd8);
    step();                             // GAP
    check("t4_stray_before", 32'(bus.stray_pixel), 32'd0);
    man_pv = 1'b1;
    step();
    man_pv = 1'b0;
    step();
    check("t4_stray", 32'(bus.stray_pixel), 32'd1);
    repeat (GAP + 2) step();
    check("t4_frames_kept", 32'(bus.frames_done), 32'd8);

    // ---------------- reset mid-RUN on a 4x4 frame
    push_one(12'd4, 12'd4);             // LOAD
    step();                             // START
    step();                             // RUN
    man_pv = 1'b1;
    repeat (3) step();
    man_pv = 1'b0;
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_ready", 32'(bus.job_ready), 32'd1);
    check("t5_size_x", 32'(bus.dut_size_x), 32'd0);
    check("t5_frames", 32'(bus.frames_done), 32'd0);
    check("t5_stray", 32'(bus.stray_pixel), 32'd0);
    check("t5_frame_done", 32'(bus.frame_done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t5_no_done_on_reset", 32'(done_cnt - d0), 32'd0);
    auto_pix = 1;
    push_one(12'd1, 12'd1);
    wait_frames(d0 + 1, 50, "t5_1x1_frame");
    repeat (GAP + 4) step();
    check("t5_frames_after", 32'(bus.frames_done), 32'd1);
    check("t5_idle", 32'(bus.busy), 32'd0);

`ifdef FRAME_SEQ_TIMEOUT_EN
    // ---------------- watchdog: 2x2 with a single pixel
    auto_pix = 0;
    d0 = done_cnt;
    push_one(12'd2, 12'd2);             // LOAD
    step();                             // START
    step();                             // RUN
    man_pv = 1'b1;
    step();
    man_pv = 1'b0;
    repeat (8) step();
    check("t6_no_timeout_yet", 32'(bus.timeout), 32'd0);
    repeat (2) step();
    check("t6_timeout", 32'(bus.timeout), 32'd1);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_frames", 32'(bus.frames_done), 32'd1);
    repeat (GAP + 4) step();
    auto_pix = 1;
    push_one(12'd1, 12'd1);
    wait_frames(d0 + 1, 50, "t6_next_frame");
    check("t6_frames_after", 32'(bus.frames_done), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
